// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch front end: FSM states, FIFO entry
// layout and the branch predecode helpers used when IF_BTFN_EN is defined.
package if_pkg;

   localparam int unsigned IF_XLEN = 32;

   localparam logic [4:0] OP_BRANCH = 5'b11000;

   typedef enum logic [1:0] {
      S_RESET = 2'd0,
      S_FETCH = 2'd1,
      S_STALL = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [IF_XLEN-1:0] pc;
      logic [IF_XLEN-1:0] inst;
      logic               pred;
   } if_entry_t;

   // RISC-V B-type immediate, bit 0 always zero, bit 12 is the sign.
   function automatic logic [12:0] b_imm(input logic [31:0] inst);
      return {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   endfunction

endpackage

// File: rtl/if_fifo.sv
// Prefetch FIFO of {pc, inst, pred} entries: synchronous push/pop/flush with
// an occupancy count. Push and pop may coincide even when full.
module if_fifo
   import if_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   push,
   input  if_entry_t              wr_data,
   input  logic                   pop,
   output if_entry_t              rd_data,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   if_entry_t     mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != CNT_FULL) || do_pop);
   assign empty   = (count == '0);
   assign rd_data = mem[rd_ptr];

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push && !rst && !flush) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
   end

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch front end: sequential ROM fetch into a prefetch FIFO with
// reset/interrupt/redirect flushing. Define IF_BTFN_EN for backward-taken predecode.
module if_prefetch
   import if_pkg::*;
#(
   parameter int unsigned XLEN    = IF_XLEN,
   parameter int unsigned IMEM_AW = 13,
   parameter int unsigned DEPTH   = 4
) (
   input  logic               clk,
   input  logic               rst_flag,
   input  logic [XLEN-1:0]    rst_addr,
   input  logic               int_flag,
   input  logic [XLEN-1:0]    int_addr,
   input  logic               redir_valid,
   input  logic [XLEN-1:0]    redir_addr,
   output logic               imem_req,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [XLEN-1:0]    imem_rdata,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [XLEN-1:0]    out_pc,
   output logic [XLEN-1:0]    out_inst,
   output logic               out_pred,
   output fetch_state_e       dbg_state
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

   // Handshake: an entry transfers on a rising edge where out_valid && out_ready;
   // out_valid never depends on out_ready and stays up until the entry is taken
   // or a redirect flushes it.

   fetch_state_e    state;
   logic [XLEN-1:0] fpc;
   logic [XLEN-1:0] tag_pc;
   logic [XLEN-1:0] hold_pc;
   logic [XLEN-1:0] hold_inst;
   logic [XLEN-1:0] redir_tgt;
   logic            epoch;
   logic            tag_epoch;
   logic            inflight;
   logic [CW-1:0]   occ;
   logic [CW-1:0]   occ_next;
   logic [CW-1:0]   used_next;
   logic            ext_redir;
   logic            any_redir;
   logic            resp_ok;
   logic            pred_taken;
   logic            issue;
   logic            push;
   logic            pop;
   logic            fifo_empty;
   if_entry_t       wr_entry;
   if_entry_t       head;

   assign ext_redir = int_flag | redir_valid;
   assign resp_ok   = inflight & (tag_epoch == epoch);

`ifdef IF_BTFN_EN
   logic [12:0] bimm;
   assign bimm       = b_imm(imem_rdata);
   assign pred_taken = resp_ok & (imem_rdata[6:2] == OP_BRANCH) & imem_rdata[31];
`else
   assign pred_taken = 1'b0;
`endif

   assign any_redir = ext_redir | pred_taken;
   // Credit reserves a FIFO slot for every in-flight request, so responses are never dropped.
   assign issue     = ~rst_flag & ~any_redir & ((occ + CW'(inflight)) < CNT_DEPTH);
   assign imem_req  = issue;
   assign imem_addr = fpc[IMEM_AW+1:2];

   always_comb begin
      redir_tgt = fpc;
      if (int_flag) begin
         redir_tgt = int_addr;
      end else if (redir_valid) begin
         redir_tgt = redir_addr;
      end
`ifdef IF_BTFN_EN
      else if (pred_taken) begin
         redir_tgt = tag_pc + {{(XLEN-13){bimm[12]}}, bimm};
      end
`endif
   end

   assign push     = resp_ok;
   assign pop      = ~fifo_empty & out_ready;
   assign wr_entry = '{pc: tag_pc, inst: imem_rdata, pred: pred_taken};

   assign occ_next  = ext_redir ? '0 : (occ + CW'(push) - CW'(pop));
   assign used_next = occ_next + CW'(issue);

   if_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst_flag),
      .flush   (ext_redir),
      .push    (push),
      .wr_data (wr_entry),
      .pop     (pop),
      .rd_data (head),
      .empty   (fifo_empty),
      .count   (occ)
   );

   always_ff @(posedge clk) begin
      if (rst_flag) begin
         fpc       <= rst_addr & ~XLEN'(3);
         epoch     <= 1'b0;
         inflight  <= 1'b0;
         tag_pc    <= '0;
         tag_epoch <= 1'b0;
         hold_pc   <= '0;
         hold_inst <= '0;
         state     <= S_RESET;
      end else begin
         inflight <= issue;
         if (issue) begin
            tag_pc    <= fpc;
            tag_epoch <= epoch;
         end
         // The epoch flip turns any response already requested into a stale one.
         if (any_redir) begin
            fpc   <= redir_tgt & ~XLEN'(3);
            epoch <= ~epoch;
         end else if (issue) begin
            fpc <= fpc + XLEN'(4);
         end
         if (!fifo_empty) begin
            hold_pc   <= head.pc;
            hold_inst <= head.inst;
         end
         state <= (used_next < CNT_DEPTH) ? S_FETCH : S_STALL;
      end
   end

   assign out_valid = ~fifo_empty;
   assign out_pc    = fifo_empty ? hold_pc : head.pc;
   assign out_inst  = fifo_empty ? hold_inst : head.inst;
   assign out_pred  = ~fifo_empty & head.pred;
   assign dbg_state = state;

endmodule
